// File: rtl/fetch_unit_if.sv
// Fetch-unit signal bundle: instruction-memory read port plus the
// PC/instruction stream exchanged with the decode/branch stage.
interface fetch_unit_if;
  logic        stall;
  logic [31:0] branchAddr;
  logic        Jump;
  logic [25:0] jumpImm;
  logic        JR;
  logic [31:0] jrAddr;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemRdata;
  logic [31:0] PC;
  logic [31:0] PCp4;
  logic [31:0] instr;
  logic        instrValid;
  logic        addrErr;

  modport master (
    input  stall, branchAddr, Jump, jumpImm, JR, jrAddr, imemReady, imemRdata,
    output imemReq, imemAddr, PC, PCp4, instr, instrValid, addrErr
  );

  modport slave (
    output stall, branchAddr, Jump, jumpImm, JR, jrAddr, imemReady, imemRdata,
    input  imemReq, imemAddr, PC, PCp4, instr, instrValid, addrErr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: request/valid two-phase FSM with JR > Jump > branch
// next-PC selection and a sticky halt on misaligned targets.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    S_REQ,
    S_VALID,
    S_HALT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pcp4;
  logic [31:0] instr_q;
  logic        imem_req_q;
  logic        instr_valid_q;
  logic        addr_err_q;
  logic [31:0] next_pc;

  assign pcp4 = pc + 32'd4;

  // Jump region comes from PC+4, not PC, so a jump in the last slot of a
  // 256MB region lands in the following region.
  always_comb begin
    next_pc = bus.branchAddr;
    if (bus.JR)
      next_pc = bus.jrAddr;
    else if (bus.Jump)
      next_pc = {pcp4[31:28], bus.jumpImm, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_REQ;
      pc            <= RESET_PC;
      instr_q       <= '0;
      addr_err_q    <= 1'b0;
      imem_req_q    <= 1'b1;
      instr_valid_q <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (bus.imemReady) begin
            instr_q       <= bus.imemRdata;
            state         <= S_VALID;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        S_VALID: begin
          if (!bus.stall) begin
            instr_valid_q <= 1'b0;
            if (next_pc[1:0] != 2'b00) begin
              addr_err_q <= 1'b1;
              state      <= S_HALT;
              imem_req_q <= 1'b0;
            end else begin
              pc         <= next_pc;
              state      <= S_REQ;
              imem_req_q <= 1'b1;
            end
          end
        end
        S_HALT: begin
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
        default: begin
          state         <= S_HALT;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imemReq    = imem_req_q;
  assign bus.imemAddr   = pc;
  assign bus.PC         = pc;
  assign bus.PCp4       = pcp4;
  assign bus.instr      = instr_q;
  assign bus.instrValid = instr_valid_q;
  assign bus.addrErr    = addr_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch addresses and instruction
// words are queued when stimulus is driven and popped when the DUT presents them.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC  = 32'h0040_0000;
  localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  int unsigned n_cmp;
  int unsigned n_err;
  logic [31:0] ea;
  logic [31:0] ei;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.stall      = 1'b0;
    bus.branchAddr = 32'h0;
    bus.Jump       = 1'b0;
    bus.jumpImm    = '0;
    bus.JR         = 1'b0;
    bus.jrAddr     = 32'h0;
    bus.imemReady  = 1'b0;
    bus.imemRdata  = GARBAGE;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_addr_q.delete();
    exp_instr_q.delete();
  endtask

  // Serve the pending request with zero wait; leaves the DUT in VALID.
  task automatic serve_now(input logic [31:0] addr);
    bus.imemReady = 1'b1;
    bus.imemRdata = mem_word(addr);
    exp_instr_q.push_back(mem_word(addr));
    tick();
    bus.imemReady = 1'b0;
    bus.imemRdata = GARBAGE;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b1;
    bus.imemReady = 1'b1;
    bus.imemRdata = 32'h1111_1111;
    tick();
    tick();
    reset = 1'b0;
    bus.imemReady = 1'b0;
    n_cmp++; if (bus.imemReq !== 1'b1) begin n_err++; $display("FAIL reset_req got %b want 1", bus.imemReq); end
    n_cmp++; if (bus.imemAddr !== RST_PC) begin n_err++; $display("FAIL reset_addr got %h want %h", bus.imemAddr, RST_PC); end
    n_cmp++; if (bus.instrValid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.instrValid); end
    n_cmp++; if (bus.addrErr !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", bus.addrErr); end
    n_cmp++; if (bus.instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", bus.instr); end
    n_cmp++; if (bus.PCp4 !== RST_PC + 32'd4) begin n_err++; $display("FAIL reset_pcp4 got %h want %h", bus.PCp4, RST_PC + 32'd4); end
  endtask

  task automatic test_sequential;
    do_reset();
    exp_addr_q.push_back(RST_PC);
    for (int i = 0; i < 3; i++) begin
      ea = exp_addr_q.pop_front();
      n_cmp++; if (bus.imemReq !== 1'b1 || bus.instrValid !== 1'b0) begin n_err++; $display("FAIL seq_req_phase req=%b valid=%b want 1/0", bus.imemReq, bus.instrValid); end
      n_cmp++; if (bus.imemAddr !== ea) begin n_err++; $display("FAIL seq_addr got %h want %h", bus.imemAddr, ea); end
      serve_now(ea);
      ei = exp_instr_q.pop_front();
      n_cmp++; if (bus.instrValid !== 1'b1 || bus.imemReq !== 1'b0) begin n_err++; $display("FAIL seq_valid_phase valid=%b req=%b want 1/0", bus.instrValid, bus.imemReq); end
      n_cmp++; if (bus.instr !== ei) begin n_err++; $display("FAIL seq_instr got %h want %h", bus.instr, ei); end
      n_cmp++; if (bus.PC !== ea) begin n_err++; $display("FAIL seq_pc got %h want %h", bus.PC, ea); end
      bus.branchAddr = ea + 32'd4;
      exp_addr_q.push_back(ea + 32'd4);
      tick();
    end
    n_cmp++; if (bus.imemAddr !== 32'h0040_000C) begin n_err++; $display("FAIL seq_fourth_addr got %h want 0040000c", bus.imemAddr); end
  endtask

  task automatic test_wait_states;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.imemRdata = GARBAGE ^ i;
      n_cmp++; if (bus.imemReq !== 1'b1 || bus.instrValid !== 1'b0 || bus.imemAddr !== RST_PC) begin
        n_err++; $display("FAIL wait_hold req=%b valid=%b addr=%h want 1/0/%h", bus.imemReq, bus.instrValid, bus.imemAddr, RST_PC);
      end
      tick();
    end
    n_cmp++; if (bus.imemReq !== 1'b1) begin n_err++; $display("FAIL wait_req4 got %b want 1", bus.imemReq); end
    serve_now(RST_PC);
    ei = exp_instr_q.pop_front();
    n_cmp++; if (bus.instrValid !== 1'b1) begin n_err++; $display("FAIL wait_valid5 got %b want 1", bus.instrValid); end
    n_cmp++; if (bus.instr !== ei) begin n_err++; $display("FAIL wait_instr got %h want %h", bus.instr, ei); end
  endtask

  task automatic test_stall;
    do_reset();
    serve_now(RST_PC);
    ei = exp_instr_q.pop_front();
    bus.stall = 1'b1;
    bus.branchAddr = 32'h0040_0020;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (bus.instrValid !== 1'b1 || bus.PC !== RST_PC || bus.instr !== ei || bus.imemReq !== 1'b0) begin
        n_err++; $display("FAIL stall_hold%0d valid=%b pc=%h instr=%h want 1/%h/%h", k, bus.instrValid, bus.PC, bus.instr, RST_PC, ei);
      end
      if (k == 2) bus.stall = 1'b0;
      tick();
    end
    n_cmp++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h0040_0020) begin
      n_err++; $display("FAIL stall_next req=%b addr=%h want 1/00400020", bus.imemReq, bus.imemAddr);
    end
  endtask

  task automatic test_jump_jr;
    do_reset();
    serve_now(RST_PC);
    bus.branchAddr = RST_PC + 32'd4;
    tick();
    serve_now(RST_PC + 32'd4);
    n_cmp++; if (bus.PCp4 !== 32'h0040_0008) begin n_err++; $display("FAIL jump_pcp4 got %h want 00400008", bus.PCp4); end
    bus.Jump = 1'b1;
    bus.jumpImm = 26'h0000010;
    bus.branchAddr = 32'h0040_0008;
    exp_addr_q.push_back(32'h0000_0040);
    tick();
    bus.Jump = 1'b0;
    ea = exp_addr_q.pop_front();
    n_cmp++; if (bus.imemAddr !== ea) begin n_err++; $display("FAIL jump_target got %h want %h", bus.imemAddr, ea); end
    serve_now(ea);
    bus.Jump = 1'b1;
    bus.JR = 1'b1;
    bus.jrAddr = 32'h0040_0100;
    bus.branchAddr = 32'h0000_0044;
    exp_addr_q.push_back(32'h0040_0100);
    tick();
    bus.Jump = 1'b0;
    bus.JR = 1'b0;
    ea = exp_addr_q.pop_front();
    n_cmp++; if (bus.imemAddr !== ea) begin n_err++; $display("FAIL jr_priority got %h want %h", bus.imemAddr, ea); end
  endtask

  task automatic test_wrap;
    do_reset();
    serve_now(RST_PC);
    bus.JR = 1'b1;
    bus.jrAddr = 32'hFFFF_FFFC;
    tick();
    bus.JR = 1'b0;
    n_cmp++; if (bus.imemAddr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr got %h want fffffffc", bus.imemAddr); end
    n_cmp++; if (bus.PCp4 !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_pcp4 got %h want 00000000", bus.PCp4); end
    serve_now(32'hFFFF_FFFC);
    bus.Jump = 1'b1;
    bus.jumpImm = 26'h3FF_FFFF;
    tick();
    bus.Jump = 1'b0;
    n_cmp++; if (bus.imemAddr !== 32'h0FFF_FFFC) begin n_err++; $display("FAIL wrap_jump_region got %h want 0ffffffc", bus.imemAddr); end
  endtask

  task automatic test_addr_err;
    do_reset();
    serve_now(RST_PC);
    bus.JR = 1'b1;
    bus.jrAddr = 32'h0040_0102;
    tick();
    bus.JR = 1'b0;
    bus.imemReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (bus.addrErr !== 1'b1 || bus.imemReq !== 1'b0 || bus.instrValid !== 1'b0 || bus.PC !== RST_PC) begin
        n_err++; $display("FAIL halt%0d err=%b req=%b valid=%b pc=%h want 1/0/0/%h", k, bus.addrErr, bus.imemReq, bus.instrValid, bus.PC, RST_PC);
      end
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.imemReady = 1'b0;
    n_cmp++; if (bus.addrErr !== 1'b0 || bus.imemReq !== 1'b1 || bus.imemAddr !== RST_PC) begin
      n_err++; $display("FAIL halt_reset err=%b req=%b addr=%h want 0/1/%h", bus.addrErr, bus.imemReq, bus.imemAddr, RST_PC);
    end
  endtask

  task automatic test_reset_mid_request;
    do_reset();
    serve_now(RST_PC);
    bus.branchAddr = RST_PC + 32'd4;
    tick();
    reset = 1'b1;
    bus.imemReady = 1'b1;
    bus.imemRdata = 32'hCAFE_F00D;
    tick();
    reset = 1'b0;
    bus.imemReady = 1'b0;
    n_cmp++; if (bus.instr !== 32'h0) begin n_err++; $display("FAIL midreset_instr got %h want 0", bus.instr); end
    n_cmp++; if (bus.instrValid !== 1'b0 || bus.imemReq !== 1'b1 || bus.imemAddr !== RST_PC) begin
      n_err++; $display("FAIL midreset_state valid=%b req=%b addr=%h want 0/1/%h", bus.instrValid, bus.imemReq, bus.imemAddr, RST_PC);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_sequential();
    test_wait_states();
    test_stall();
    test_jump_jr();
    test_wrap();
    test_addr_err();
    test_reset_mid_request();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout sim_time=%0t limit=200000", $time);
    $fatal(1, "timeout");
  end
endmodule
